// File: rtl/config_stream_sequencer.sv
// rtl/config_stream_sequencer.sv - serialises 32-bit config words onto parallel config chains
module config_stream_sequencer #(
    parameter  int CHAINS    = 4,
    parameter  int WORD_W    = 32,
    parameter  int CHAIN_LEN = 256,
    localparam int SPW       = WORD_W / CHAINS,
    localparam int NWORDS    = CHAIN_LEN / SPW,
    localparam int CNT_W     = $clog2(NWORDS + 1)
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              word_valid_i,
    input  logic [WORD_W-1:0] word_data_i,
    output logic              word_ready_o,
    output logic              cen,
    output logic [CHAINS-1:0] shift_out,
    output logic [CHAINS-1:0] set_out,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  word_cnt_o
);

    localparam int KW = (SPW > 1) ? $clog2(SPW) : 1;
    localparam logic [KW-1:0]    K_LAST   = KW'(SPW - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NWORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SHIFT,
        S_SET,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              xfer;

    logic              ready_q, ready_d;
    logic              cen_q, cen_d;
    logic [CHAINS-1:0] shift_q, shift_d;
    logic [CHAINS-1:0] set_q, set_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Next-state logic: abort wins over everything, a word is taken only when ready was advertised.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        xfer    = word_valid_i & ready_q & ~abort_i;
        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i && !abort_i) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end
                end
                S_WAIT: begin
                    if (xfer) begin
                        state_d = S_SHIFT;
                        k_d     = '0;
                        sreg_d  = word_data_i;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (k_q != K_LAST) begin
                        k_d    = k_q + 1'b1;
                        sreg_d = sreg_q >> CHAINS;
                    end else if (xfer) begin
                        // gapless hand-over: the next word starts shifting immediately
                        k_d    = '0;
                        sreg_d = word_data_i;
                        cnt_d  = cnt_q + 1'b1;
                    end else if (cnt_q == CNT_FULL) begin
                        state_d = S_SET;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_SET:   state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output decode of the next state so every output leaves the block straight from a flop.
    always_comb begin
        ready_d = 1'b0;
        cen_d   = 1'b0;
        shift_d = '0;
        set_d   = '0;
        done_d  = 1'b0;
        busy_d  = (state_d != S_IDLE);
        unique case (state_d)
            S_WAIT:  ready_d = 1'b1;
            S_SHIFT: begin
                cen_d   = 1'b1;
                shift_d = sreg_d[CHAINS-1:0];
                ready_d = (k_d == K_LAST) && (cnt_d != CNT_FULL);
            end
            S_SET:   set_d  = '1;
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    // Control state, shift register and word counter.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ready_q <= 1'b0;
            cen_q   <= 1'b0;
            shift_q <= '0;
            set_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ready_q <= ready_d;
            cen_q   <= cen_d;
            shift_q <= shift_d;
            set_q   <= set_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign word_ready_o = ready_q;
    assign cen          = cen_q;
    assign shift_out    = shift_q;
    assign set_out      = set_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign word_cnt_o   = cnt_q;

endmodule
